// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - multi-cycle shift-add-3 binary to BCD converter with sign, overflow and blanking
module bin2bcd_seq #(
  parameter int BIN_W  = 18,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  signed_mode,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              state, state_nxt;
  logic [BIN_W-1:0]    mag;
  logic [4*DIGITS-1:0] work;
  logic [4*DIGITS-1:0] adj;
  logic                work_ovf;
  logic                work_neg;
  logic [CNT_W-1:0]    cnt;
  logic [DIGITS-1:0]   blank_nxt;
  logic                zero_above;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  // Digits 5..9 become 8..12 so the following shift carries into the next digit.
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d +: 4] = (work[4*d +: 4] >= 4'd5) ? work[4*d +: 4] + 4'd3 : work[4*d +: 4];
    end
  end

  always_comb begin
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (work[4*i +: 4] == 4'd0);
      blank_nxt[i] = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag      <= '0;
      work     <= '0;
      work_ovf <= 1'b0;
      work_neg <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      bcd      <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
      blank    <= BLANK_RST;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag      <= (signed_mode && bin[BIN_W-1]) ? (~bin + 1'b1) : bin;
            work_neg <= signed_mode & bin[BIN_W-1];
            work     <= '0;
            work_ovf <= 1'b0;
            cnt      <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          // A carry out of the top digit is a multiple of 10^DIGITS lost; record it as overflow.
          work     <= {adj[4*DIGITS-2:0], mag[BIN_W-1]};
          work_ovf <= work_ovf | adj[4*DIGITS-1];
          mag      <= {mag[BIN_W-2:0], 1'b0};
          cnt      <= cnt - 1'b1;
        end
        FINISH: begin
          bcd      <= work;
          overflow <= work_ovf;
          neg      <= work_neg;
          blank    <= blank_nxt;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - randomized self-checking bench for bin2bcd_seq against a decimal reference model
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start0, sm0, ready0, done0, neg0, ovf0;
  logic [17:0] bin0;
  logic [23:0] bcd0;
  logic [5:0]  blank0;

  logic        start1, sm1, ready1, done1, neg1, ovf1;
  logic [15:0] bin1;
  logic [15:0] bcd1;
  logic [3:0]  blank1;

  int n_checks = 0;
  int n_fail   = 0;
  longint prev_bcd0 = 0;

  bin2bcd_seq #(.BIN_W(18), .DIGITS(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0), .signed_mode(sm0),
    .ready(ready0), .done(done0), .bcd(bcd0), .neg(neg0), .overflow(ovf0), .blank(blank0)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1), .signed_mode(sm1),
    .ready(ready1), .done(done1), .bcd(bcd1), .neg(neg1), .overflow(ovf1), .blank(blank1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: magnitude by arithmetic, digits by repeated division.
  function automatic void ref_model(input int w, input int d, input longint b, input bit sm,
                                    output longint ebcd, output bit eneg, output bit eovf,
                                    output longint eblank);
    longint m, lim;
    bit zero;
    eneg = sm && (((b >> (w - 1)) & 1) == 1);
    m    = eneg ? ((64'sd1 << w) - b) : b;
    lim  = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    eovf = (m >= lim);
    ebcd = 0;
    for (int i = 0; i < d; i++) begin
      ebcd = ebcd | ((m % 10) << (4 * i));
      m    = m / 10;
    end
    eblank = 0;
    zero   = 1'b1;
    for (int i = d - 1; i >= 1; i--) begin
      zero = zero && (((ebcd >> (4 * i)) & 15) == 0);
      if (zero) eblank = eblank | (64'sd1 << i);
    end
  endfunction

  // Called just after a falling edge; returns just after the falling edge where done is seen.
  task automatic convert0(input longint b, input bit s, input bit noise);
    longint eb, ebl;
    bit en, eo, seen;
    int n;
    ref_model(18, 6, b, s, eb, en, eo, ebl);
    check("ready0_idle", ready0, 1);
    start0 = 1'b1; bin0 = b[17:0]; sm0 = s;
    @(posedge clk);
    n = 1; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      if (n == 1) begin
        check("hold_bcd0", bcd0, prev_bcd0);
        check("busy0", ready0, 0);
      end
      if (done0) seen = 1'b1;
      else begin
        start0 = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bin0   = 18'($urandom);
        sm0    = 1'($urandom_range(0, 1));
        @(posedge clk);
        n++;
      end
    end
    start0 = 1'b0;
    check("done0_seen", seen, 1);
    check("latency0", n, 20);
    check("bcd0", bcd0, eb);
    check("neg0", neg0, en);
    check("ovf0", ovf0, eo);
    check("blank0", blank0, ebl);
    prev_bcd0 = eb;
  endtask

  task automatic convert1(input longint b, input bit s);
    longint eb, ebl;
    bit en, eo, seen;
    int n;
    ref_model(16, 4, b, s, eb, en, eo, ebl);
    check("ready1_idle", ready1, 1);
    start1 = 1'b1; bin1 = b[15:0]; sm1 = s;
    @(posedge clk);
    n = 1; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
      else begin
        start1 = 1'b0;
        @(posedge clk);
        n++;
      end
    end
    start1 = 1'b0;
    check("done1_seen", seen, 1);
    check("latency1", n, 18);
    check("bcd1", bcd1, eb);
    check("neg1", neg1, en);
    check("ovf1", ovf1, eo);
    check("blank1", blank1, ebl);
  endtask

  initial begin
    bit got_done;
    rst_n = 1'b0;
    start0 = 1'b0; bin0 = '0; sm0 = 1'b0;
    start1 = 1'b0; bin1 = '0; sm1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready0, 1);
    check("rst_done", done0, 0);
    check("rst_bcd", bcd0, 0);
    check("rst_neg", neg0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_blank", blank0, 6'b111110);
    check("rst_blank1", blank1, 4'b1110);
    rst_n = 1'b1;
    @(negedge clk);

    convert0(0, 0, 0);
    convert0(262143, 0, 0);
    convert0(9, 0, 0);
    convert0(18'h3FFFF, 1, 0);
    convert0(18'h20000, 1, 0);
    convert0(18'h20000, 0, 0);
    convert0(123456, 0, 1);
    convert0(999999 & 18'h3FFFF, 0, 1);
    for (int i = 0; i < 30; i++)
      convert0(longint'($urandom & 32'h3FFFF), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Abort a conversion with reset in the middle of SHIFT.
    start0 = 1'b1; bin0 = 18'd4321; sm0 = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", ready0, 1);
    check("abort_done", done0, 0);
    check("abort_bcd", bcd0, 0);
    check("abort_neg", neg0, 0);
    check("abort_ovf", ovf0, 0);
    check("abort_blank", blank0, 6'b111110);
    got_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done0) got_done = 1'b1;
    end
    check("abort_no_done", got_done, 0);
    prev_bcd0 = 0;
    convert0(1000, 0, 0);

    convert1(12345, 0);
    convert1(9999, 0);
    convert1(16'hFFFF, 1);
    convert1(16'h8000, 1);
    for (int i = 0; i < 10; i++)
      convert1(longint'($urandom & 32'hFFFF), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter that runs the shift-add-3 algorithm one input bit per clock, with a start/ready/done handshake. It replaces the single-cycle combinational converter on display and score paths where timing is tight. It adds signed input, a decimal overflow flag and leading-zero blanking.

Parameters:
BIN_W, 18, input binary width (≥2)
DIGITS, 6, number of BCD digits produced (≥1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  request conversion; accepted only when ready=1
bin  in  BIN_W  binary operand, sampled on the accepting edge
signed_mode  in  1  1: bin is two's complement; sampled with bin
ready  out  1  1 when idle and able to accept start
done  out  1  one-cycle pulse: results valid
bcd  out  4*DIGITS  result digits, {most significant … ones}, 4 bits per digit
neg  out  1  result is negative (signed_mode=1 and bin MSB=1)
overflow  out  1  magnitude > 10^DIGITS − 1
blank  out  DIGITS  bit i=1: digit i is a leading zero (bit 0 always 0)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a rising edge): FSM→IDLE, ready=1, done=0, bcd=0, neg=0, overflow=0, blank={DIGITS-1{1'b1}},1'b0. Reset mid-conversion aborts the conversion with no done pulse.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE: ready=1. On start=1:
  - Capture magnitude: if signed_mode=1 and bin[BIN_W-1]=1, mag = (~bin+1) truncated to BIN_W bits; otherwise mag = bin. The most-negative input gives 2^(BIN_W-1), which is correct unsigned.
  - Latch neg.
  - Clear the working BCD register and the sticky overflow bit.
  - Load bit counter = BIN_W.
  - Go to SHIFT.
- SHIFT: ready=0. Each cycle, in order:
  - Add 3 to every working digit that is ≥5.
  - Shift {work_bcd, mag} left one bit.
  - Set sticky overflow if the bit leaving the top of digit DIGITS-1 is 1.
  - Decrement the counter; after BIN_W shift cycles, go to FINISH.
- FINISH, one cycle: copy work_bcd→bcd, overflow, neg to outputs. Compute blank:
  - blank[i]=1 iff digits i..DIGITS-1 are all zero, for i≥1.
  - blank[0]=0.
  - Assert done=1 for this cycle only, then return to IDLE.
- Latency: with start accepted at edge k, done is high in the cycle after edge k+BIN_W+1, i.e. BIN_W+2 cycles from request to done. Throughput is one conversion per BIN_W+2 cycles.
- Output holding: outputs hold their values until the next FINISH. They are not cleared by start.
- start while ready=0 is ignored, with no queuing. start is accepted in the IDLE cycle immediately after FINISH.
- On overflow, bcd holds mag mod 10^DIGITS. Digits stay valid 0–9; no saturation.
- neg is reported even for zero magnitude only if the input MSB was set, which cannot occur for value 0.
- bin and signed_mode are don't-care outside the accepting edge.
- Arithmetic: digit corrections are 4-bit and never exceed 12 before the shift. There is no carry between digits other than through the shift.

Test Plan:
- Defaults, unsigned 0 → bcd=0x000000, blank=6'b111110, neg=0, overflow=0, done exactly 20 cycles after start.
- Unsigned 262143 (all ones) → bcd=0x262143, blank=0, overflow=0. Unsigned 9 → bcd=0x000009, blank=6'b111110.
- signed_mode=1, bin=18'h3FFFF (−1) → bcd=0x000001, neg=1. bin=18'h20000 → bcd=0x131072, neg=1, overflow=0.
- Instance BIN_W=16, DIGITS=4, bin=12345 → overflow=1, bcd=0x2345, blank=0. bin=9999 → overflow=0, bcd=0x9999.
- Handshake: start pulses during SHIFT are ignored and the result is unchanged. Back-to-back starts on every ready cycle give done pulses exactly BIN_W+2 cycles apart, each with the correct result.
- Drop rst_n for one edge mid-SHIFT → no done pulse, all outputs at reset values, ready=1 on the next cycle. The next conversion of 1000 gives 0x001000.
